// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package imem_loader_pkg;
    localparam logic [31:0] BASE_ADDR = 32'h0000_3000;
    localparam int          IM_DEPTH  = 4096;
    localparam int          CNT_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;
endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four stream bytes MSB-first into a 32-bit word; word_done pulses
// combinationally on the accepting cycle of the 4th byte, with word valid then.
module word_packer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    input  logic        clr,
    output logic [31:0] word,
    output logic        word_done
);
    logic [23:0] shift_q;
    logic [1:0]  byte_idx;

    assign word      = {shift_q, byte_in};
    assign word_done = byte_en && (byte_idx == 2'd3);

    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            shift_q  <= '0;
            byte_idx <= '0;
        end else if (byte_en) begin
            shift_q  <= {shift_q[15:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; keeps the core held
// until a full frame with a matching XOR checksum has been written.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);
    localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(IM_DEPTH);

    state_t             state, state_nxt;
    logic               fire, begin_load, hdr_byte, last_word;
    logic [CNT_W-1:0]   count_n, word_idx, hdr_n;
    logic [7:0]         xor_acc;
    logic [31:0]        word;
    logic               word_done;

    assign rx_ready   = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
    assign fire       = rx_valid && rx_ready;
    assign begin_load = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign hdr_n      = {count_n[CNT_W-1:8], rx_data};
    assign last_word  = (word_idx == count_n - 1'b1);

    // Flags are pure state decodes so cpu_hold and done move on the same edge.
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign cpu_hold = (state != S_DONE);

    word_packer u_pack (
        .Clk       (Clk),
        .Rst       (Rst),
        .byte_in   (rx_data),
        .byte_en   (fire && (state == S_DATA)),
        .clr       (begin_load),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR;
            S_HDR:  if (fire && hdr_byte)
                        state_nxt = ((hdr_n == '0) || (hdr_n > DEPTH_N)) ? S_ERR : S_DATA;
            S_DATA: if (word_done && last_word) state_nxt = S_CHK;
            S_CHK:  if (fire) state_nxt = (rx_data == xor_acc) ? S_DONE : S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hdr_byte <= 1'b0;
            count_n  <= '0;
            word_idx <= '0;
            xor_acc  <= '0;
            im_we    <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= '0;
        end else begin
            im_we <= 1'b0;
            if (begin_load) begin
                hdr_byte <= 1'b0;
                word_idx <= '0;
                xor_acc  <= '0;
            end
            if (fire && (state == S_HDR)) begin
                if (!hdr_byte) count_n[CNT_W-1:8] <= rx_data;
                else           count_n <= hdr_n;
                hdr_byte <= 1'b1;
            end
            if (fire && (state == S_DATA))
                xor_acc <= xor_acc ^ rx_data;
            if (word_done) begin
                im_we    <= 1'b1;
                im_addr  <= BASE_ADDR + 32'({word_idx, 2'b00});
                im_wdata <= word;
                word_idx <= word_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: frame table applied in a loop, plus reset and mid-load-reset sequences.
module tb_imem_loader;
    logic        Clk = 1'b0;
    logic        Rst, start, rx_valid, rx_ready, im_we, cpu_hold, done, err;
    logic [7:0]  rx_data;
    logic [31:0] im_addr, im_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] wq[$];

    imem_loader dut (
        .Clk(Clk), .Rst(Rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (im_we) wq.push_back({im_addr, im_wdata});

    typedef struct {
        string      name;
        logic [7:0] b [0:10];
        int         n;
        bit         gaps;
        int         nw;
        logic       dn;
        logic       er;
    } frame_t;

    frame_t vec [0:4];
    logic [7:0]  good [0:10];
    logic [31:0] exp_addr [0:1];
    logic [31:0] exp_data [0:1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge Clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge Clk);
            t++;
        end
        if (!rx_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(negedge Clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int nw);
        chk({tag, "_nwrites"}, 32'(wq.size()), 32'(nw));
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wq[i][63:32], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), wq[i][31:0],  exp_data[i]);
        end
    endtask

    initial begin
        good = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h2C};
        exp_addr = '{32'h0000_3000, 32'h0000_3004};
        exp_data = '{32'h2401_0005, 32'h0000_000C};

        vec[0].name = "good";     vec[0].b = good; vec[0].n = 11; vec[0].gaps = 0;
        vec[0].nw = 2; vec[0].dn = 1; vec[0].er = 0;
        vec[1].name = "gaps";     vec[1].b = good; vec[1].n = 11; vec[1].gaps = 1;
        vec[1].nw = 2; vec[1].dn = 1; vec[1].er = 0;
        vec[2].name = "badsum";   vec[2].b = good; vec[2].b[10] = 8'h2D; vec[2].n = 11;
        vec[2].gaps = 0; vec[2].nw = 2; vec[2].dn = 0; vec[2].er = 1;
        vec[3].name = "n_zero";   vec[3].b = good; vec[3].b[0] = 8'h00; vec[3].b[1] = 8'h00;
        vec[3].n = 2; vec[3].gaps = 0; vec[3].nw = 0; vec[3].dn = 0; vec[3].er = 1;
        vec[4].name = "n_4097";   vec[4].b = good; vec[4].b[0] = 8'h10; vec[4].b[1] = 8'h01;
        vec[4].n = 2; vec[4].gaps = 0; vec[4].nw = 0; vec[4].dn = 0; vec[4].er = 1;

        Rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_im_we",    32'(im_we),    32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_im_addr",  im_addr,       32'h0000_3000);
        chk("rst_im_wdata", im_wdata,      32'h0);
        @(negedge Clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);

        for (int v = 0; v < 5; v++) begin
            wq.delete();
            pulse_start();
            chk({vec[v].name, "_hdr_ready"}, 32'(rx_ready), 32'd1);
            for (int k = 0; k < vec[v].n; k++)
                send_byte(vec[v].b[k],
                          (vec[v].gaps && k > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0);
            @(negedge Clk);
            check_writes(vec[v].name, vec[v].nw);
            chk({vec[v].name, "_done"},     32'(done),     32'(vec[v].dn));
            chk({vec[v].name, "_err"},      32'(err),      32'(vec[v].er));
            chk({vec[v].name, "_cpu_hold"}, 32'(cpu_hold), 32'(!vec[v].dn));
            chk({vec[v].name, "_rx_ready"}, 32'(rx_ready), 32'd0);
        end

        // Reset after two data bytes of word 0, then reload cleanly.
        wq.delete();
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(good[k], 0);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midrst_nwrites", 32'(wq.size()), 32'd0);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_done",     32'(done),     32'd0);
        pulse_start();
        for (int k = 0; k < 11; k++) send_byte(good[k], 0);
        @(negedge Clk);
        check_writes("reload", 2);
        chk("reload_done",     32'(done),     32'd1);
        chk("reload_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("reload_err",      32'(err),      32'd0);

        // Leaving DONE re-asserts hold on the same edge.
        pulse_start();
        chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done",     32'(done),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
